// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed shift-add multiply / restoring divide sequencer
// Define MULTDIV_EARLY_TERM_EN to let a multiply finish once its remaining multiplier bits are zero.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg;
    logic               r_is_div;
    logic               r_divz;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;
    logic               r_rdy;
    logic               r_busy;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mult_sum;
    logic [2*WIDTH-1:0] w_mult_next;
    logic [2*WIDTH-1:0] w_div_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_quot_signed;
    logic               w_mult_ovf;
    logic               w_div_ovf;
    logic               w_last;
`ifdef MULTDIV_EARLY_TERM_EN
    logic [WIDTH-1:0]   w_rem_mask;
    logic               w_early;
    logic [2*WIDTH-1:0] w_early_p;
`endif

    always_comb begin
        w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        // Multiply step: the carry out of the upper-half add becomes the new MSB after the shift.
        w_mult_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
        w_mult_next = r_p[0] ? {w_mult_sum, r_p[WIDTH-1:1]} : {1'b0, r_p[2*WIDTH-1:1]};

        // Restoring divide step: keep the trial remainder only when it did not borrow.
        w_div_shift = {r_p[2*WIDTH-2:0], 1'b0};
        w_trial     = {1'b0, w_div_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_mag_b};
        w_div_next  = w_trial[WIDTH] ? w_div_shift
                                     : {w_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};

        w_prod_signed = r_neg ? -r_p : r_p;
        w_mult_ovf    = w_prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_signed[WIDTH-1]}};
        w_quot_signed = r_neg ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
        // Only a positive quotient of magnitude 2^(WIDTH-1) (MIN / -1) is unrepresentable.
        w_div_ovf     = r_p[WIDTH-1] & ~r_neg;

        w_last = (r_count == CW'(WIDTH - 1));
`ifdef MULTDIV_EARLY_TERM_EN
        // Low WIDTH-count bits of the product register still hold unconsumed multiplier bits.
        w_rem_mask = {WIDTH{1'b1}} >> r_count;
        w_early    = !r_is_div && ((r_p[WIDTH-1:0] & w_rem_mask) == '0);
        w_early_p  = r_p >> (CW'(WIDTH) - r_count);
`endif
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_neg       <= 1'b0;
            r_is_div    <= 1'b0;
            r_divz      <= 1'b0;
            r_count     <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_mult || ctrl_div) begin
                        r_mag_a  <= w_abs_a;
                        r_mag_b  <= w_abs_b;
                        r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        r_is_div <= !ctrl_mult;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_p      <= {{WIDTH{1'b0}}, (ctrl_mult ? w_abs_b : w_abs_a)};
                        if (!ctrl_mult && data_operandB == '0) begin
                            r_divz  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_divz  <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CW'(1);
`ifdef MULTDIV_EARLY_TERM_EN
                    if (w_early) begin
                        r_p     <= w_early_p;
                        r_state <= S_DONE;
                    end else
`endif
                    begin
                        r_p <= r_is_div ? w_div_next : w_mult_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b1;
                    if (r_divz) begin
                        r_result    <= '0;
                        r_exception <= 1'b1;
                    end else if (r_is_div) begin
                        r_result    <= w_quot_signed;
                        r_exception <= w_div_ovf;
                    end else begin
                        r_result    <= w_prod_signed[WIDTH-1:0];
                        r_exception <= w_mult_ovf;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule
